// File: rtl/loba_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loba_pkg
// Description : Shared types and default constants for the LOBA accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package loba_pkg;

  localparam int c_N         = 16;
  localparam int c_ACC_W     = 40;
  localparam int c_CNT_W     = 8;
  localparam int c_FRAME_MAX = 255;

  // ACC gathers products; HOLD presents a finished frame until it is taken.
  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } loba_acc_state_t;

endpackage
`default_nettype wire

// File: rtl/loba_sat_add.sv
`default_nettype none
// ============================================================================
// Module      : loba_sat_add
// Description : Unsigned saturating add of an accumulator and a zero-extended
//               product. Flags when the true sum does not fit.
// Revision    : 1.0 - initial release
// ============================================================================
module loba_sat_add #(
  parameter int ACC_W = 40,
  parameter int P_W   = 32
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [P_W-1:0]   p,
  output logic [ACC_W-1:0] sum,
  output logic             sat
);

  // One extra bit catches the carry out of the accumulator width.
  logic [ACC_W:0] w_full;

  assign w_full = {1'b0, acc} + (ACC_W+1)'(p);
  assign sat    = w_full[ACC_W];
  assign sum    = w_full[ACC_W] ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];

endmodule
`default_nettype wire

// File: rtl/loba_acc.sv
`default_nettype none
// ============================================================================
// Module      : loba_acc
// Description : Streaming saturating accumulator for LOBA multiplier products.
//               Closes a frame on in_last or after FRAME_MAX products and
//               holds the frame result on a valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module loba_acc
  import loba_pkg::*;
#(
  parameter int N         = c_N,
  parameter int ACC_W     = c_ACC_W,
  parameter int CNT_W     = c_CNT_W,
  parameter int FRAME_MAX = c_FRAME_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   in_p,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);

  localparam logic [CNT_W-1:0] c_frame_max = CNT_W'(FRAME_MAX);

  loba_acc_state_t r_state, w_state_nxt;

  logic [ACC_W-1:0] r_acc, w_acc_nxt, w_sum;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             r_ovf, w_ovf_nxt, w_sat;
  logic             w_close;

  loba_sat_add #(
    .ACC_W (ACC_W),
    .P_W   (2*N)
  ) u_sat_add (
    .acc (r_acc),
    .p   (in_p),
    .sum (w_sum),
    .sat (w_sat)
  );

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Handshake outputs come straight from the state register.
  assign in_ready  = (r_state == ACC);
  assign out_valid = (r_state == HOLD);

  // Next state and next accumulator contents; clr overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    w_close     = 1'b0;
    if (clr) begin
      w_state_nxt = ACC;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
      w_ovf_nxt   = 1'b0;
    end else begin
      case (r_state)
        ACC: begin
          if (in_valid) begin
            w_acc_nxt = w_sum;
            w_cnt_nxt = w_cnt_inc;
            w_ovf_nxt = r_ovf | w_sat;
            // in_last and the count limit may coincide; either closes once.
            if (in_last || (w_cnt_inc == c_frame_max)) begin
              w_close     = 1'b1;
              w_state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            w_state_nxt = ACC;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
          end
        end
        default: w_state_nxt = ACC;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACC;
    else        r_state <= w_state_nxt;
  end

  // Running frame accumulator, product count and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_acc <= w_acc_nxt;
      r_cnt <= w_cnt_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  // Result registers capture the post-add frame totals when a frame closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum <= '0;
      out_cnt <= '0;
      out_ovf <= 1'b0;
    end else if (w_close) begin
      out_sum <= w_acc_nxt;
      out_cnt <= w_cnt_nxt;
      out_ovf <= w_ovf_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_loba_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_loba_acc
// Description : Directed self-checking bench for loba_acc (ACC_W=32, N=16,
//               FRAME_MAX=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_loba_acc;

  localparam int c_N         = 16;
  localparam int c_ACC_W     = 32;
  localparam int c_CNT_W     = 8;
  localparam int c_FRAME_MAX = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clr = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [2*c_N-1:0]     in_p = '0;
  logic                 in_last = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [c_ACC_W-1:0]   out_sum;
  logic [c_CNT_W-1:0]   out_cnt;
  logic                 out_ovf;

  int n_vec = 0;
  int n_err = 0;

  loba_acc #(
    .N         (c_N),
    .ACC_W     (c_ACC_W),
    .CNT_W     (c_CNT_W),
    .FRAME_MAX (c_FRAME_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cnt   (out_cnt),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] p, input logic l);
    in_valid = v;
    in_p     = p;
    in_last  = l;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent;
    int results;

    // Reset values
    #3;
    check_vec("rst_in_ready", in_ready, 1);
    check_vec("rst_out_valid", out_valid, 0);
    check_vec("rst_out_sum", out_sum, 0);
    check_vec("rst_out_cnt", out_cnt, 0);
    check_vec("rst_out_ovf", out_ovf, 0);
    #4 rst_n = 1'b1;
    step();

    // Basic frame 3+5+7
    drive(1, 3, 0); step();
    drive(1, 5, 0); step();
    drive(1, 7, 1); step();
    drive(0, 0, 0);
    check_vec("basic_valid", out_valid, 1);
    check_vec("basic_in_ready", in_ready, 0);
    check_vec("basic_sum", out_sum, 15);
    check_vec("basic_cnt", out_cnt, 3);
    check_vec("basic_ovf", out_ovf, 0);
    step();
    check_vec("basic_valid_drop", out_valid, 0);
    check_vec("basic_ready_back", in_ready, 1);

    // Backpressure
    out_ready = 1'b0;
    drive(1, 32'hFFFF_FFFF, 1); step();
    drive(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      check_vec("bp_valid", out_valid, 1);
      check_vec("bp_in_ready", in_ready, 0);
      check_vec("bp_sum", out_sum, 64'hFFFF_FFFF);
      if (i == 4) out_ready = 1'b1;
      step();
    end
    check_vec("bp_release_ready", in_ready, 1);
    drive(1, 2, 1); step();
    drive(0, 0, 0);
    check_vec("bp_next_valid", out_valid, 1);
    check_vec("bp_next_sum", out_sum, 2);
    check_vec("bp_next_cnt", out_cnt, 1);
    step();

    // Saturation
    drive(1, 32'hFFFF_FFFF, 0); step();
    drive(1, 2, 1); step();
    drive(0, 0, 0);
    check_vec("sat_sum", out_sum, 64'hFFFF_FFFF);
    check_vec("sat_ovf", out_ovf, 1);
    check_vec("sat_cnt", out_cnt, 2);
    step();

    // Force-close: eight 1s without in_last
    sent = 0;
    results = 0;
    for (int cyc = 0; cyc < 30 && sent < 8; cyc++) begin
      drive(1, 1, 0);
      if (in_ready) sent++;
      step();
      if (out_valid) begin
        results++;
        check_vec("fc_sum", out_sum, 4);
        check_vec("fc_cnt", out_cnt, 4);
        check_vec("fc_ovf", out_ovf, 0);
      end
    end
    drive(0, 0, 0);
    step();
    check_vec("fc_sent", sent, 8);
    check_vec("fc_results", results, 2);
    check_vec("fc_idle", out_valid, 0);

    // FRAME_MAX and in_last on the same product close once
    drive(1, 1, 0); step(); step(); step();
    drive(1, 1, 1); step();
    drive(0, 0, 0);
    check_vec("both_valid", out_valid, 1);
    check_vec("both_cnt", out_cnt, 4);
    step();
    check_vec("both_single", out_valid, 0);
    step();
    check_vec("both_no_dbl", out_valid, 0);

    // Clear mid-frame
    drive(1, 10, 0); step(); step();
    clr = 1'b1;
    drive(1, 10, 0); step();
    clr = 1'b0;
    check_vec("clr_in_ready", in_ready, 1);
    check_vec("clr_no_valid", out_valid, 0);
    out_ready = 1'b0;
    drive(1, 1, 1); step();
    drive(0, 0, 0);
    check_vec("clr_sum", out_sum, 1);
    check_vec("clr_cnt", out_cnt, 1);
    check_vec("clr_hold_valid", out_valid, 1);

    // Clear while holding drops the result
    clr = 1'b1; step();
    clr = 1'b0;
    check_vec("clrh_valid", out_valid, 0);
    check_vec("clrh_in_ready", in_ready, 1);
    out_ready = 1'b1;
    drive(1, 6, 1); step();
    drive(0, 0, 0);
    check_vec("clrh_next_sum", out_sum, 6);
    check_vec("clrh_next_cnt", out_cnt, 1);
    step();

    // Asynchronous reset mid-frame
    drive(1, 9, 0); step(); step();
    drive(0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check_vec("arst_valid", out_valid, 0);
    check_vec("arst_in_ready", in_ready, 1);
    check_vec("arst_sum", out_sum, 0);
    check_vec("arst_cnt", out_cnt, 0);
    #1 rst_n = 1'b1;
    step();
    drive(1, 4, 1); step();
    drive(0, 0, 0);
    check_vec("arst_next_sum", out_sum, 4);
    check_vec("arst_next_cnt", out_cnt, 1);
    check_vec("arst_next_ovf", out_ovf, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
